irq_vec_arbiter: RTL and testbench
==================================

Name: irq_vec_arbiter

Overview:
- Sits directly downstream of the per-line interrupt edge-capture shim.
- Consumes its 16 sticky irq_req lines and returns a one-cycle irq_ack to each serviced line.
- Round-robin arbitrates among the pending, enabled lines and presents one vector at a time to the host user-interrupt interface, using a level req/ack handshake (XDMA usr_irq style).
- Flags host non-response with a sticky timeout error.

Parameters:
- NUM_IRQ, 16: number of interrupt lines; 2..32.
- VEC_W, 4: vector width; must equal ceil(log2(NUM_IRQ)).
- ACK_TIMEOUT, 1024: cycles to wait for msi_ack; 0 disables the timeout.

Ports:
- clk  in  1  single clock, same domain as the shim.
- rst  in  1  asynchronous, active-high reset.
- irq_req  in  NUM_IRQ  sticky pending lines from the shim.
- irq_ack  out  NUM_IRQ  one-cycle clear pulse to the shim, at most one bit high.
- irq_en  in  NUM_IRQ  per-line enable; a disabled line is never granted.
- msi_req  out  1  host interrupt request; level, held until acked or timed out.
- msi_vec  out  VEC_W  vector of the granted line; stable while msi_req=1.
- msi_ack  in  1  host acknowledge; sampled only in ISSUE.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on timeout.
- err_clr  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset values (applied asynchronously):
  - state=IDLE; irq_ack=0; msi_req=0; msi_vec=0; timeout_err=0; timer=0.
  - last_grant=NUM_IRQ-1, so the first search starts at line 0.
- Eligible vector = irq_req & irq_en.
- Round-robin search: starts at last_grant+1 and wraps modulo NUM_IRQ; the first eligible line wins.
- State machine:
  - IDLE: if eligible!=0, register the winner into msi_vec and last_grant, set msi_req=1, clear timer, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: if msi_ack=1, drop msi_req and go to ACK. Else, if ACK_TIMEOUT!=0 and timer==ACK_TIMEOUT-1, drop msi_req, set timeout_err, go to IDLE without acking the source (the line stays pending and will be retried after the other lines). Else timer+1.
  - ACK: irq_ack[last_grant]=1 for exactly this cycle, then go to IDLE.
- Latency:
  - Eligible visible in cycle t → msi_req=1 at t+1.
  - msi_ack in cycle a → irq_ack pulse in a+1 → IDLE in a+2 → next msi_req no earlier than a+3.
  - The shim clears irq_req on the edge ending a+1, so IDLE in a+2 sees the cleared line; no double service.
- Simultaneous events:
  - A new edge on the serviced line during the ACK cycle keeps its req high in the shim. The arbiter re-services it after the other eligible lines; none are lost.
  - msi_ack and timeout expiry in the same cycle: msi_ack wins, no error.
  - err_clr and timeout expiry in the same cycle: set wins.
- Changes to irq_en or irq_req while in ISSUE or ACK do not alter msi_vec or the ack target.
- msi_ack outside ISSUE is ignored.
- Timer is $clog2(ACK_TIMEOUT+1) bits and does not wrap while in ISSUE.
- Reset mid-handshake drops msi_req and irq_ack in the same cycle. No ack is issued, so the shim line stays pending for the host to rediscover.

Decomposition:
- Shared irq package holds:
  - the state enum (IDLE, ISSUE, ACK);
  - NUM_IRQ_DEF=16 and VEC_W_DEF=4;
  - a function for the round-robin next-index search.
- One natural sub-module, rr_pick: combinational rotate, priority-encode and un-rotate. It takes eligible and last_grant and returns valid and index; reusable by other arbiters.

Test Plan:
- Reset, then irq_req=0x0001, irq_en=0xFFFF → msi_req=1, msi_vec=0 one cycle later. Drive msi_ack for 1 cycle → irq_ack=0x0001 for exactly 1 cycle, busy low two cycles after the ack.
- irq_req=0x8011 held, acked immediately each time → service order 0, 4, 15, 0 (wrap).
- irq_req=0x0006, irq_en=0x0004 → only vector 2 is issued; line 1 is never acked while disabled.
- ACK_TIMEOUT=8, irq_req=0x0008, no msi_ack → msi_req falls after 8 cycles and timeout_err=1. irq_ack stays 0 and the line is re-issued. err_clr → timeout_err=0.
- Pulse irq_req[3] again during the ACK cycle for line 3, with the shim model keeping req high → line 3 is serviced a second time, after any other pending lines.
- Assert rst while in ISSUE with msi_vec=5 → msi_req=0 immediately. After release, the first grant is the lowest pending line (search from 0).

Source files
------------

// File: rtl/irq_vec_arbiter_pkg.sv
// Shared definitions for the interrupt vector arbiter: FSM states, default
// sizing and the round-robin search start helper.
package irq_vec_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } irq_state_e;

  localparam int NUM_IRQ_DEF = 16;
  localparam int VEC_W_DEF   = 4;

  // First index examined by a round-robin search, one past the previous winner.
  function automatic int rr_start_idx(input int last_grant, input int num_lines);
    if (last_grant + 32'sd1 >= num_lines) begin
      return 32'sd0;
    end else begin
      return last_grant + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/irq_vec_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector to the search
// start, take the lowest set bit, and map it back to an absolute index.
module irq_vec_arbiter_rr_pick
  import irq_vec_arbiter_pkg::*;
#(
  parameter int N = NUM_IRQ_DEF,
  parameter int W = VEC_W_DEF
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last_grant,
  output logic         valid,
  output logic [W-1:0] index
);

  logic [2*N-1:0] doubled_s;
  logic [N-1:0]   rotated_s;
  int             start_s;
  int             pos_s;
  int             sum_s;

  // Rotate, priority-encode from bit 0, then un-rotate modulo N.
  always_comb begin
    start_s   = rr_start_idx(int'(last_grant), N);
    doubled_s = {eligible, eligible};
    rotated_s = N'(doubled_s >> start_s);
    pos_s     = 32'sd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated_s[i]) begin
        pos_s = i;
      end else begin
        pos_s = pos_s;
      end
    end
    sum_s = start_s + pos_s;
    if (sum_s >= N) begin
      sum_s = sum_s - N;
    end else begin
      sum_s = sum_s;
    end
    valid = |eligible;
    index = W'(sum_s);
  end

endmodule

// File: rtl/irq_vec_arbiter.sv
// Round-robin interrupt vector arbiter between the edge-capture shim and a
// level req/ack host interrupt port, with a sticky host-timeout flag.
module irq_vec_arbiter
  import irq_vec_arbiter_pkg::*;
#(
  parameter int NUM_IRQ     = NUM_IRQ_DEF,
  parameter int VEC_W       = VEC_W_DEF,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic [NUM_IRQ-1:0] irq_en,
  output logic               msi_req,
  output logic [VEC_W-1:0]   msi_vec,
  input  logic               msi_ack,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int TMR_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam bit TMO_EN = (ACK_TIMEOUT > 0);
  localparam logic [NUM_IRQ-1:0] LINE0 = NUM_IRQ'(1'b1);
  localparam logic [VEC_W-1:0] LAST_LINE = VEC_W'(NUM_IRQ - 1);

  irq_state_e         state_r, state_s;
  logic [VEC_W-1:0]   last_grant_r, last_grant_s;
  logic [VEC_W-1:0]   msi_vec_s, pick_idx_s;
  logic [NUM_IRQ-1:0] eligible_s, irq_ack_s;
  logic [TMR_W-1:0]   timer_r, timer_s;
  logic               pick_valid_s, msi_req_s, timeout_err_s, busy_s, tmo_hit_s;

  assign eligible_s = irq_req & irq_en;

  irq_vec_arbiter_rr_pick #(
    .N (NUM_IRQ),
    .W (VEC_W)
  ) u_rr_pick (
    .eligible   (eligible_s),
    .last_grant (last_grant_r),
    .valid      (pick_valid_s),
    .index      (pick_idx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, grant history and host-response timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= LAST_LINE;
      msi_vec      <= {VEC_W{1'b0}};
      msi_req      <= 1'b0;
      irq_ack      <= {NUM_IRQ{1'b0}};
      timer_r      <= {TMR_W{1'b0}};
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      last_grant_r <= last_grant_s;
      msi_vec      <= msi_vec_s;
      msi_req      <= msi_req_s;
      irq_ack      <= irq_ack_s;
      timer_r      <= timer_s;
      timeout_err  <= timeout_err_s;
      busy         <= busy_s;
    end
  end

  // Next-state and next-output logic; the ack pulse is launched on entry to ACK.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    msi_vec_s    = msi_vec;
    msi_req_s    = msi_req;
    irq_ack_s    = {NUM_IRQ{1'b0}};
    timer_s      = timer_r;
    tmo_hit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          last_grant_s = pick_idx_s;
          msi_vec_s    = pick_idx_s;
          msi_req_s    = 1'b1;
          timer_s      = {TMR_W{1'b0}};
          state_s      = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (msi_ack) begin
          msi_req_s = 1'b0;
          irq_ack_s = LINE0 << last_grant_r;
          state_s   = ST_ACK;
        end else if (TMO_EN && (timer_r == TMR_LAST)) begin
          msi_req_s = 1'b0;
          tmo_hit_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (timer_r != TMR_MAX) begin
          timer_s = timer_r + TMR_W'(1'b1);
        end else begin
          timer_s = timer_r;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        msi_req_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
    if (tmo_hit_s) begin
      timeout_err_s = 1'b1;
    end else if (err_clr) begin
      timeout_err_s = 1'b0;
    end else begin
      timeout_err_s = timeout_err;
    end
    busy_s = (state_s != ST_IDLE);
  end

endmodule

// File: tb/tb_irq_vec_arbiter.sv
// Bench for irq_vec_arbiter: directed table, handshake corner sequences and a
// randomized run against a transaction-level reference model.
module tb_irq_vec_arbiter;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_req, irq_ack, irq_en;
  logic         msi_req;
  logic [W-1:0] msi_vec;
  logic         msi_ack, busy, timeout_err, err_clr;

  logic         shim_rst;
  logic [N-1:0] set_pulse, hold_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_vec_arbiter #(.NUM_IRQ(N), .VEC_W(W), .ACK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .irq_en      (irq_en),
    .msi_req     (msi_req),
    .msi_vec     (msi_vec),
    .msi_ack     (msi_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  // Shim model: sticky request, a new edge wins over the ack clear.
  always_ff @(posedge clk or posedge shim_rst) begin
    if (shim_rst) irq_req <= '0;
    else          irq_req <= (irq_req & ~irq_ack) | set_pulse | hold_mask;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; shim_rst = 1'b1;
    set_pulse = '0; hold_mask = '0; msi_ack = 1'b0; err_clr = 1'b0; irq_en = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0; shim_rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (msi_req === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_msi_req actual=no_request required=msi_req_within_40_cycles");
    end
  endtask

  task automatic service(input int exp, input logic [N-1:0] repulse);
    bit ok;
    wait_req(ok);
    if (ok) begin
      chk("msi_vec", 32'(msi_vec), 32'(exp));
      msi_ack = 1'b1;
      @(negedge clk);
      msi_ack = 1'b0;
      chk("irq_ack_pulse", 32'(irq_ack), 32'd1 << exp);
      chk("msi_req_drop", 32'(msi_req), 32'd0);
      chk("busy_in_ack", 32'(busy), 32'd1);
      set_pulse = repulse;
      @(negedge clk);
      set_pulse = '0;
      chk("irq_ack_single", 32'(irq_ack), 32'd0);
      chk("busy_after_ack", 32'(busy), 32'd0);
    end
  endtask

  // Transaction-level reference model.
  int           m_phase, m_last, m_wait;
  logic [W-1:0] m_vec;
  logic         m_req, m_err;
  logic [N-1:0] m_ack;

  task automatic model_reset();
    m_phase = 0; m_last = N - 1; m_wait = 0;
    m_vec = '0; m_req = 1'b0; m_err = 1'b0; m_ack = '0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] en,
                            input logic ack, input logic clr);
    logic [N-1:0] elig;
    bit expired;
    elig = req & en;
    expired = 1'b0;
    m_ack = '0;
    if (m_phase == 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (elig[idx]) begin
          m_last = idx; m_vec = W'(idx); m_req = 1'b1; m_wait = 0; m_phase = 1;
          break;
        end
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        m_req = 1'b0; m_ack[m_last] = 1'b1; m_phase = 2;
      end else if (m_wait == TO - 1) begin
        m_req = 1'b0; expired = 1'b1; m_phase = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_phase = 0;
    end
    if (expired) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]       req;
    logic [N-1:0]       en;
    bit                 hold;
    int                 n;
    logic [3:0][W-1:0]  v;
    bit                 quiet;
  } vec_t;

  vec_t tbl[4];

  initial begin
    bit ok;
    int cnt;
    logic [N-1:0] acks;

    tbl[0] = '{req: 16'h0001, en: 16'hFFFF, hold: 1'b0, n: 1, v: {4'd0, 4'd0, 4'd0, 4'd0},  quiet: 1'b1};
    tbl[1] = '{req: 16'h8011, en: 16'hFFFF, hold: 1'b1, n: 4, v: {4'd0, 4'd15, 4'd4, 4'd0}, quiet: 1'b0};
    tbl[2] = '{req: 16'h0006, en: 16'h0004, hold: 1'b0, n: 1, v: {4'd0, 4'd0, 4'd0, 4'd2},  quiet: 1'b1};
    tbl[3] = '{req: 16'h00A0, en: 16'hFFFF, hold: 1'b0, n: 2, v: {4'd0, 4'd0, 4'd7, 4'd5},  quiet: 1'b1};

    do_reset();
    chk("reset_msi_req", 32'(msi_req), 32'd0);
    chk("reset_msi_vec", 32'(msi_vec), 32'd0);
    chk("reset_irq_ack", 32'(irq_ack), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      irq_en = tbl[t].en;
      if (tbl[t].hold) hold_mask = tbl[t].req;
      else             set_pulse = tbl[t].req;
      @(negedge clk);
      set_pulse = '0;
      chk("pre_latency", 32'(msi_req), 32'd0);
      @(negedge clk);
      chk("latency", 32'(msi_req), 32'd1);
      for (int k = 0; k < tbl[t].n; k++) service(int'(tbl[t].v[k]), '0);
      hold_mask = '0;
      if (tbl[t].quiet) begin
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
          if (msi_req || (irq_ack != '0)) cnt++;
          @(negedge clk);
        end
        chk("quiet_after_service", 32'(cnt), 32'd0);
      end
    end

    // Host never answers: timeout, no ack, line retried, then error cleared.
    do_reset();
    set_pulse = 16'h0008;
    @(negedge clk);
    set_pulse = '0;
    wait_req(ok);
    cnt = 0; acks = '0;
    while (msi_req && cnt < 20) begin
      cnt++; acks |= irq_ack;
      @(negedge clk);
    end
    chk("timeout_len", 32'(cnt), 32'(TO));
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_no_ack", 32'(acks), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    service(3, '0);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("timeout_err_clr", 32'(timeout_err), 32'd0);

    // New edge on line 3 during its ACK cycle: serviced again after line 6.
    do_reset();
    set_pulse = 16'h0048;
    @(negedge clk);
    set_pulse = '0;
    service(3, 16'h0008);
    service(6, '0);
    service(3, '0);
    chk("reedge_drained", 32'(irq_req), 32'd0);

    // Reset while issuing vector 5; restart searches from line 0.
    do_reset();
    set_pulse = 16'h0020;
    @(negedge clk);
    set_pulse = '0;
    wait_req(ok);
    chk("pre_reset_vec", 32'(msi_vec), 32'd5);
    set_pulse = 16'h0084;
    @(negedge clk);
    set_pulse = '0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_msi_req", 32'(msi_req), 32'd0);
    chk("async_reset_irq_ack", 32'(irq_ack), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_req(ok);
    chk("post_reset_first_vec", 32'(msi_vec), 32'd2);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_msi_req", 32'(msi_req), 32'(m_req));
      chk("rnd_msi_vec", 32'(msi_vec), 32'(m_vec));
      chk("rnd_irq_ack", 32'(irq_ack), 32'(m_ack));
      chk("rnd_busy", 32'(busy), 32'(m_phase != 0));
      chk("rnd_timeout_err", 32'(timeout_err), 32'(m_err));
      set_pulse = ($urandom_range(0, 3) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
      if ($urandom_range(0, 31) == 0) irq_en = 16'($urandom) | 16'($urandom);
      msi_ack = ($urandom_range(0, 2) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      model_step(irq_req, irq_en, msi_ack, err_clr);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
